// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multi-cycle control FSM and its opcode classifier.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam logic [6:0] OpcI    = 7'b0010011;
  localparam logic [6:0] OpcL    = 7'b0000011;
  localparam logic [6:0] OpcR    = 7'b0110011;
  localparam logic [6:0] OpcS    = 7'b0100011;
  localparam logic [6:0] OpcSb   = 7'b1100011;
  localparam logic [6:0] OpcU    = 7'b0110111;
  localparam logic [6:0] OpcUj   = 7'b1101111;
  localparam logic [6:0] OpcJalr = 7'b1100111;

  typedef enum logic [3:0] {
    ClsNone = 4'd0,
    ClsI    = 4'd1,
    ClsL    = 4'd2,
    ClsR    = 4'd3,
    ClsS    = 4'd4,
    ClsSb   = 4'd5,
    ClsU    = 4'd6,
    ClsUj   = 4'd7,
    ClsJalr = 4'd8
  } class_e;

  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluFunct  = 2'b01;
  localparam logic [1:0] AluBranch = 2'b10;
  localparam logic [1:0] AluLui    = 2'b11;

  localparam logic [1:0] WbAlu  = 2'b00;
  localparam logic [1:0] WbLoad = 2'b01;
  localparam logic [1:0] WbPc4  = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: instruction in, memory handshake and datapath enables.
interface multicycle_controller_if;

  logic [31:0] instruction;
  logic        mem_ack;
  logic        mem_req;
  logic        iorD;
  logic        irWrite;
  logic        pcWrite;
  logic        aluSrc;
  logic        branch;
  logic        jump;
  logic        memRd;
  logic        memWrt;
  logic        regWrt;
  logic [1:0]  aluOp;
  logic [1:0]  memToReg;

  modport master (
    input  instruction, mem_ack,
    output mem_req, iorD, irWrite, pcWrite, aluSrc, branch, jump,
           memRd, memWrt, regWrt, aluOp, memToReg
  );

  modport slave (
    output instruction, mem_ack,
    input  mem_req, iorD, irWrite, pcWrite, aluSrc, branch, jump,
           memRd, memWrt, regWrt, aluOp, memToReg
  );

endinterface

// File: rtl/multicycle_controller_opcode_classifier.sv
// Combinational opcode -> {class, legal}; also intended for the pipelined decoder.
module opcode_classifier
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_JALR = 1'b1
) (
  input  logic [6:0] opcode,
  output class_e     op_class,
  output logic       legal
);

  // Map the major opcode to its instruction class; unknown opcodes are illegal.
  always_comb begin
    op_class = ClsNone;
    legal    = 1'b1;
    case (opcode)
      OpcI:    op_class = ClsI;
      OpcL:    op_class = ClsL;
      OpcR:    op_class = ClsR;
      OpcS:    op_class = ClsS;
      OpcSb:   op_class = ClsSb;
      OpcU:    op_class = ClsU;
      OpcUj:   op_class = ClsUj;
      OpcJalr: begin
        if (SUPPORT_JALR) op_class = ClsJalr;
        else              legal    = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared req/ack memory port,
// with illegal-opcode and memory-timeout traps and a retired-instruction counter.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned CNT_W        = 32,
  parameter bit          SUPPORT_JALR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_controller_if.master  bus,
  output logic [2:0]               state,
  output logic                     trap,
  output logic                     retire,
  output logic [CNT_W-1:0]         instret
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  state_e           state_q;
  class_e           class_q;
  logic [WaitW-1:0] wait_q;
  logic [CNT_W-1:0] instret_q;

  class_e dec_class;
  logic   dec_legal;
  logic   mem_phase;
  logic   timeout;
  logic   pc_write;
  logic   unused_instr;

  // Only the major opcode matters to the controller.
  assign unused_instr = ^bus.instruction[31:7];

  opcode_classifier #(
    .SUPPORT_JALR (SUPPORT_JALR)
  ) u_classifier (
    .opcode   (bus.instruction[6:0]),
    .op_class (dec_class),
    .legal    (dec_legal)
  );

  assign mem_phase = (state_q == StFetch) || (state_q == StMem);
  // An ack in the deadline cycle still wins over the timeout.
  assign timeout   = (MEM_TIMEOUT != 0) && (wait_q == WaitMax) && !bus.mem_ack;

  // State sequencing, class latch, memory wait counter and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      class_q   <= ClsNone;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      if (retire) instret_q <= instret_q + CNT_W'(1);

      // Counts stalled request cycles; any ack, timeout or state change restarts it.
      if (mem_phase && !bus.mem_ack && !timeout) begin
        if (wait_q != WaitMax) wait_q <= wait_q + WaitW'(1);
      end else begin
        wait_q <= '0;
      end

      unique case (state_q)
        StFetch: begin
          if (bus.mem_ack)  state_q <= StDecode;
          else if (timeout) state_q <= StTrap;
        end
        StDecode: begin
          class_q <= dec_class;
          state_q <= dec_legal ? StExec : StTrap;
        end
        StExec: begin
          case (class_q)
            ClsSb:      state_q <= StFetch;
            ClsL, ClsS: state_q <= StMem;
            default:    state_q <= StWb;
          endcase
        end
        StMem: begin
          if (bus.mem_ack)  state_q <= (class_q == ClsL) ? StWb : StFetch;
          else if (timeout) state_q <= StTrap;
        end
        StWb:    state_q <= StFetch;
        StTrap:  state_q <= StTrap;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Datapath controls decoded from state and class; mem_ack only feeds the Mealy terms.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.iorD     = 1'b0;
    bus.irWrite  = 1'b0;
    bus.aluSrc   = 1'b0;
    bus.branch   = 1'b0;
    bus.jump     = 1'b0;
    bus.memRd    = 1'b0;
    bus.memWrt   = 1'b0;
    bus.regWrt   = 1'b0;
    bus.aluOp    = AluAdd;
    bus.memToReg = WbAlu;
    pc_write     = 1'b0;
    case (state_q)
      StFetch: begin
        bus.mem_req = 1'b1;
        bus.memRd   = 1'b1;
        bus.irWrite = bus.mem_ack;
      end
      StExec: begin
        case (class_q)
          ClsI: begin
            bus.aluSrc = 1'b1;
            bus.aluOp  = AluFunct;
          end
          ClsL, ClsS: bus.aluSrc = 1'b1;
          ClsR:       bus.aluOp  = AluFunct;
          ClsSb: begin
            bus.aluOp  = AluBranch;
            bus.branch = 1'b1;
            pc_write   = 1'b1;
          end
          ClsU: begin
            bus.aluSrc = 1'b1;
            bus.aluOp  = AluLui;
          end
          ClsUj, ClsJalr: begin
            bus.aluSrc = 1'b1;
            bus.jump   = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        bus.mem_req = 1'b1;
        bus.iorD    = 1'b1;
        bus.memRd   = (class_q == ClsL);
        bus.memWrt  = (class_q == ClsS);
        pc_write    = (class_q == ClsS) && bus.mem_ack;
      end
      StWb: begin
        bus.regWrt = 1'b1;
        pc_write   = 1'b1;
        bus.jump   = (class_q == ClsUj) || (class_q == ClsJalr);
        if (class_q == ClsL) bus.memToReg = WbLoad;
        else if ((class_q == ClsUj) || (class_q == ClsJalr)) bus.memToReg = WbPc4;
      end
      default: ;
    endcase
  end

  assign bus.pcWrite = pc_write;
  assign retire      = pc_write;
  assign trap        = (state_q == StTrap);
  assign state       = state_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected traces built from the instruction
// step rules, with randomized stalls and ignored acks. DUT a uses default parameters,
// DUT b has CNT_W=4, no JALR and the timeout disabled.
module tb_multicycle_controller;

  typedef struct packed {
    logic [2:0] st;
    logic       req, iord, irw, pcw, alusrc, br, jmp, mrd, mwr, rwr;
    logic [1:0] aluop, m2r;
    logic       trp, ret;
  } exp_t;

  typedef enum int {KI, KL, KR, KS, KSB, KU, KUJ, KJALR, KBAD} kind_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [2:0]  state_a, state_b;
  logic        trap_a, trap_b, retire_a, retire_b;
  logic [31:0] instret_a;
  logic [3:0]  instret_b;

  multicycle_controller_if bus_a ();
  multicycle_controller_if bus_b ();

  multicycle_controller #(
    .MEM_TIMEOUT (15), .CNT_W (32), .SUPPORT_JALR (1'b1)
  ) dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a), .state (state_a),
    .trap (trap_a), .retire (retire_a), .instret (instret_a)
  );

  multicycle_controller #(
    .MEM_TIMEOUT (0), .CNT_W (4), .SUPPORT_JALR (1'b0)
  ) dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b), .state (state_b),
    .trap (trap_b), .retire (retire_b), .instret (instret_b)
  );

  int   checks = 0;
  int   fails  = 0;
  int   retired_a = 0;
  int   retired_b = 0;
  exp_t q_exp[$];
  logic q_ack[$];

  // ---------------- expected-step builders ----------------
  function automatic exp_t e_fetch(logic ack);
    exp_t e = '0;
    e.st = 3'd0; e.req = 1'b1; e.mrd = 1'b1; e.irw = ack;
    return e;
  endfunction

  function automatic exp_t e_decode();
    exp_t e = '0;
    e.st = 3'd1;
    return e;
  endfunction

  function automatic exp_t e_exec(kind_t k);
    exp_t e = '0;
    e.st = 3'd2;
    case (k)
      KI:        begin e.alusrc = 1'b1; e.aluop = 2'b01; end
      KL, KS:    begin e.alusrc = 1'b1; e.aluop = 2'b00; end
      KR:        begin e.alusrc = 1'b0; e.aluop = 2'b01; end
      KSB:       begin e.aluop = 2'b10; e.br = 1'b1; e.pcw = 1'b1; e.ret = 1'b1; end
      KU:        begin e.alusrc = 1'b1; e.aluop = 2'b11; end
      KUJ, KJALR: begin e.alusrc = 1'b1; e.aluop = 2'b00; e.jmp = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t e_mem(kind_t k, logic ack);
    exp_t e = '0;
    e.st = 3'd3; e.req = 1'b1; e.iord = 1'b1;
    e.mrd = (k == KL); e.mwr = (k == KS);
    e.pcw = (k == KS) && ack; e.ret = (k == KS) && ack;
    return e;
  endfunction

  function automatic exp_t e_wb(kind_t k);
    exp_t e = '0;
    e.st = 3'd4; e.rwr = 1'b1; e.pcw = 1'b1; e.ret = 1'b1;
    e.jmp = (k == KUJ) || (k == KJALR);
    e.m2r = (k == KL) ? 2'b01 : ((k == KUJ) || (k == KJALR)) ? 2'b10 : 2'b00;
    return e;
  endfunction

  function automatic exp_t e_trap();
    exp_t e = '0;
    e.st = 3'd5; e.trp = 1'b1;
    return e;
  endfunction

  function automatic logic [6:0] opc_of(kind_t k);
    case (k)
      KI:      return 7'b0010011;
      KL:      return 7'b0000011;
      KR:      return 7'b0110011;
      KS:      return 7'b0100011;
      KSB:     return 7'b1100011;
      KU:      return 7'b0110111;
      KUJ:     return 7'b1101111;
      KJALR:   return 7'b1100111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t observe(bit sel);
    exp_t o;
    if (!sel) begin
      o.st = state_a; o.req = bus_a.mem_req; o.iord = bus_a.iorD; o.irw = bus_a.irWrite;
      o.pcw = bus_a.pcWrite; o.alusrc = bus_a.aluSrc; o.br = bus_a.branch; o.jmp = bus_a.jump;
      o.mrd = bus_a.memRd; o.mwr = bus_a.memWrt; o.rwr = bus_a.regWrt; o.aluop = bus_a.aluOp;
      o.m2r = bus_a.memToReg; o.trp = trap_a; o.ret = retire_a;
    end else begin
      o.st = state_b; o.req = bus_b.mem_req; o.iord = bus_b.iorD; o.irw = bus_b.irWrite;
      o.pcw = bus_b.pcWrite; o.alusrc = bus_b.aluSrc; o.br = bus_b.branch; o.jmp = bus_b.jump;
      o.mrd = bus_b.memRd; o.mwr = bus_b.memWrt; o.rwr = bus_b.regWrt; o.aluop = bus_b.aluOp;
      o.m2r = bus_b.memToReg; o.trp = trap_b; o.ret = retire_b;
    end
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic push(exp_t e, logic a);
    q_exp.push_back(e);
    q_ack.push_back(a);
  endtask

  // Full instruction: fw stalled fetch cycles, mw stalled memory cycles; acks outside
  // FETCH/MEM are random since they must be ignored.
  task automatic plan_instr(bit sel, kind_t k, int fw, int mw);
    for (int i = 0; i < fw; i++) push(e_fetch(1'b0), 1'b0);
    push(e_fetch(1'b1), 1'b1);
    push(e_decode(), 1'($urandom));
    if (k == KBAD) begin
      for (int i = 0; i < 5; i++) push(e_trap(), 1'($urandom));
      return;
    end
    push(e_exec(k), 1'($urandom));
    if (k == KL || k == KS) begin
      for (int i = 0; i < mw; i++) push(e_mem(k, 1'b0), 1'b0);
      push(e_mem(k, 1'b1), 1'b1);
    end
    if (k != KSB && k != KS) push(e_wb(k), 1'($urandom));
    if (sel) retired_b++;
    else     retired_a++;
  endtask

  task automatic play(bit sel, logic [31:0] instr, string tag);
    exp_t obs;
    for (int i = 0; i < q_exp.size(); i++) begin
      if (sel) begin bus_b.instruction = instr; bus_b.mem_ack = q_ack[i]; end
      else     begin bus_a.instruction = instr; bus_a.mem_ack = q_ack[i]; end
      #1;
      obs = observe(sel);
      checks++;
      assert (obs === q_exp[i]) else begin
        fails++;
        $error("FAIL %s cycle %0d: observed %h expected %h", tag, i + 1, obs, q_exp[i]);
      end
      @(negedge clk);
    end
    if (sel) bus_b.mem_ack = 1'b0;
    else     bus_a.mem_ack = 1'b0;
    q_exp.delete();
    q_ack.delete();
  endtask

  task automatic check_instret(bit sel, string tag);
    logic [31:0] obs, req;
    #1;
    obs = sel ? {28'd0, instret_b} : instret_a;
    req = sel ? 32'(retired_b % 16) : 32'(retired_a);
    checks++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s instret: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  // Called at a negedge; one reset edge, then checks the post-reset FETCH outputs.
  task automatic do_reset(bit sel, string tag);
    exp_t obs;
    if (sel) begin rst_b = 1'b1; bus_b.mem_ack = 1'b0; end
    else     begin rst_a = 1'b1; bus_a.mem_ack = 1'b0; end
    @(negedge clk);
    if (sel) begin rst_b = 1'b0; retired_b = 0; end
    else     begin rst_a = 1'b0; retired_a = 0; end
    #1;
    obs = observe(sel);
    checks++;
    assert (obs === e_fetch(1'b0)) else begin
      fails++;
      $error("FAIL %s reset outputs: observed %h expected %h", tag, obs, e_fetch(1'b0));
    end
    check_instret(sel, tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    kind_t       k;
    logic [31:0] r;
    exp_t        obs;

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.instruction = '0; bus_a.mem_ack = 1'b0;
    bus_b.instruction = '0; bus_b.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    obs = observe(1'b0);
    checks++;
    assert (obs === e_fetch(1'b0)) else begin
      fails++; $error("FAIL reset_a: observed %h expected %h", obs, e_fetch(1'b0));
    end
    obs = observe(1'b1);
    checks++;
    assert (obs === e_fetch(1'b0)) else begin
      fails++; $error("FAIL reset_b: observed %h expected %h", obs, e_fetch(1'b0));
    end
    check_instret(1'b0, "reset_a");
    check_instret(1'b1, "reset_b");

    // R-type back to back
    for (int n = 0; n < 2; n++) begin
      plan_instr(1'b0, KR, 0, 0);
      play(1'b0, 32'h00B50533, "rtype");
    end
    check_instret(1'b0, "rtype");

    // Branch
    plan_instr(1'b0, KSB, 0, 0);
    play(1'b0, 32'h00B50463, "branch");
    check_instret(1'b0, "branch");

    // Load with two memory wait cycles
    plan_instr(1'b0, KL, 0, 2);
    play(1'b0, 32'h0002A303, "load_wait");
    check_instret(1'b0, "load_wait");

    // Random legal instructions with random stalls
    for (int n = 0; n < 40; n++) begin
      k = kind_t'($urandom_range(0, 7));
      r = $urandom;
      plan_instr(1'b0, k, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      play(1'b0, {r[31:7], opc_of(k)}, "random_a");
      check_instret(1'b0, "random_a");
    end

    // Ack in the 16th fetch cycle beats the timeout
    plan_instr(1'b0, KR, 15, 0);
    play(1'b0, 32'h00B50533, "ack_at_limit");
    check_instret(1'b0, "ack_at_limit");

    // Fetch timeout: no ack for 16 cycles
    for (int i = 0; i < 16; i++) push(e_fetch(1'b0), 1'b0);
    for (int i = 0; i < 4; i++) push(e_trap(), 1'($urandom));
    play(1'b0, 32'h00B50533, "fetch_timeout");
    check_instret(1'b0, "fetch_timeout");
    do_reset(1'b0, "after_fetch_timeout");

    // Memory timeout on a load
    push(e_fetch(1'b1), 1'b1);
    push(e_decode(), 1'b0);
    push(e_exec(KL), 1'b0);
    for (int i = 0; i < 16; i++) push(e_mem(KL, 1'b0), 1'b0);
    for (int i = 0; i < 3; i++) push(e_trap(), 1'($urandom));
    play(1'b0, 32'h0002A303, "mem_timeout");
    do_reset(1'b0, "after_mem_timeout");

    // Illegal opcode
    plan_instr(1'b0, KBAD, 0, 0);
    play(1'b0, 32'h0000007F, "illegal");
    check_instret(1'b0, "illegal");
    do_reset(1'b0, "after_illegal");
    plan_instr(1'b0, KU, 1, 0);
    play(1'b0, 32'h123452B7, "after_trap_lui");
    check_instret(1'b0, "after_trap_lui");

    // DUT b: JALR illegal when unsupported
    do_reset(1'b1, "b_start");
    plan_instr(1'b1, KBAD, 0, 0);
    play(1'b1, 32'h000080E7, "jalr_unsupported");
    check_instret(1'b1, "jalr_unsupported");
    do_reset(1'b1, "after_jalr_trap");

    // 17 retires on a 4-bit counter; first one stalls past 15 with the timeout disabled
    for (int n = 0; n < 17; n++) begin
      k = kind_t'($urandom_range(0, 6));
      r = $urandom;
      plan_instr(1'b1, k, (n == 0) ? 20 : int'($urandom_range(0, 3)),
                 (n == 0) ? 20 : int'($urandom_range(0, 3)));
      play(1'b1, {r[31:7], opc_of(k)}, "wrap_b");
      check_instret(1'b1, "wrap_b");
    end

    // Reset during MEM of a store aborts it without retiring
    push(e_fetch(1'b1), 1'b1);
    push(e_decode(), 1'b0);
    push(e_exec(KS), 1'b0);
    push(e_mem(KS, 1'b0), 1'b0);
    push(e_mem(KS, 1'b0), 1'b0);
    play(1'b1, 32'h00B52023, "store_abort");
    do_reset(1'b1, "store_abort_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
